// File: rtl/mux5_rr_scheduler_pkg.sv
// Shared types and helpers for the five-source round-robin channel scheduler.
package mux5_sched_pkg;

  localparam int N_REQ     = 5;
  localparam int DATA_W    = 3;
  localparam int DWELL_MAX = 15;

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_MANUAL
  } state_t;

  // Out-of-range indices yield an all-zero vector rather than aliasing a source.
  function automatic logic [N_REQ-1:0] onehot5(input logic [2:0] idx);
    onehot5 = '0;
    if (idx < 3'd5) onehot5[idx] = 1'b1;
  endfunction

  // Slot select with indices 4..7 all mapping to source y.
  function automatic logic [DATA_W-1:0] slot5(input logic [N_REQ*DATA_W-1:0] d,
                                              input logic [2:0] idx);
    case (idx)
      3'd0:    slot5 = d[2:0];
      3'd1:    slot5 = d[5:3];
      3'd2:    slot5 = d[8:6];
      3'd3:    slot5 = d[11:9];
      default: slot5 = d[14:12];
    endcase
  endfunction

endpackage

// File: rtl/mux5_rr_scheduler_if.sv
// Request/data/grant bundle between the sources and the scheduler; no flow control.
interface mux5_rr_scheduler_if;
  import mux5_sched_pkg::*;

  logic [N_REQ-1:0]        req;
  logic [N_REQ*DATA_W-1:0] data_in;
  logic                    manual_en;
  logic [2:0]              manual_sel;
  logic [N_REQ-1:0]        grant;
  logic [2:0]              sel;
  logic [DATA_W-1:0]       m;
  logic                    m_valid;

  modport master (
    output req, data_in, manual_en, manual_sel,
    input  grant, sel, m, m_valid
  );

  modport slave (
    input  req, data_in, manual_en, manual_sel,
    output grant, sel, m, m_valid
  );

endinterface

// File: rtl/mux5_rr_scheduler_rr_pick5.sv
// Circular priority picker: first asserted request at or after ptr, modulo 5.
// Purely combinational; no backpressure.
module rr_pick5
  import mux5_sched_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [2:0]       ptr,
  output logic             any,
  output logic [2:0]       idx
);

  logic [3:0] cand;

  // Scan from the far end so the candidate closest to ptr is the last one written.
  always_comb begin
    any  = 1'b0;
    idx  = 3'd0;
    cand = 4'd0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = {1'b0, ptr} + 4'(k);
      if (cand >= 4'd10)     cand = cand - 4'd10;
      else if (cand >= 4'd5) cand = cand - 4'd5;
      if (req[cand[2:0]]) begin
        any = 1'b1;
        idx = cand[2:0];
      end
    end
  end

endmodule

// File: rtl/mux5_rr_scheduler.sv
// Round-robin scheduler sharing one 3-bit channel among five sources, with manual override.
// Grant/sel one edge after request, m/m_valid one edge later; no backpressure.
module mux5_rr_scheduler
  import mux5_sched_pkg::*;
#(
  parameter int DWELL = 4
) (
  input logic               CLOCK_50,
  input logic               Resetn,
  mux5_rr_scheduler_if.slave bus
);

  state_t            state, state_nxt;
  logic [2:0]        ptr, ptr_nxt;
  logic [2:0]        sel, sel_nxt;
  logic [3:0]        dwell_cnt, dwell_nxt;
  logic [N_REQ-1:0]  grant, grant_nxt;
  logic [DATA_W-1:0] m, m_nxt;
  logic              m_valid, m_valid_nxt;

  logic [2:0] msel, adv, pick_ptr, pick_idx;
  logic       pick_any, expire;

  assign msel   = (bus.manual_sel > 3'd4) ? 3'd4 : bus.manual_sel;
  assign adv    = (sel == 3'd4) ? 3'd0 : sel + 3'd1;
  assign expire = (dwell_cnt == 4'(DWELL)) || !bus.req[sel];

  // While granting, arbitration must already see the advanced pointer on the ending edge.
  assign pick_ptr = (state == S_GRANT) ? adv : ptr;

  rr_pick5 u_pick (
    .req (bus.req),
    .ptr (pick_ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    sel_nxt     = sel;
    dwell_nxt   = dwell_cnt;
    grant_nxt   = grant;
    m_nxt       = m;
    m_valid_nxt = 1'b0;

    if (bus.manual_en) begin
      state_nxt   = S_MANUAL;
      sel_nxt     = msel;
      grant_nxt   = onehot5(msel);
      m_nxt       = slot5(bus.data_in, msel);
      m_valid_nxt = 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          grant_nxt = '0;
          if (pick_any) begin
            state_nxt = S_GRANT;
            sel_nxt   = pick_idx;
            grant_nxt = onehot5(pick_idx);
            dwell_nxt = 4'd1;
          end
        end
        S_GRANT: begin
          m_nxt       = slot5(bus.data_in, sel);
          m_valid_nxt = 1'b1;
          if (expire) begin
            ptr_nxt = adv;
            if (pick_any) begin
              sel_nxt   = pick_idx;
              grant_nxt = onehot5(pick_idx);
              dwell_nxt = 4'd1;
            end else begin
              state_nxt = S_IDLE;
              grant_nxt = '0;
            end
          end else begin
            dwell_nxt = dwell_cnt + 4'd1;
          end
        end
        S_MANUAL: begin
          m_nxt       = slot5(bus.data_in, sel);
          m_valid_nxt = 1'b1;
          state_nxt   = S_IDLE;
          grant_nxt   = '0;
        end
        default: begin
          state_nxt = S_IDLE;
          grant_nxt = '0;
        end
      endcase
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!Resetn) begin
      state     <= S_IDLE;
      ptr       <= 3'd0;
      sel       <= 3'd0;
      dwell_cnt <= 4'd0;
      grant     <= '0;
      m         <= '0;
      m_valid   <= 1'b0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      sel       <= sel_nxt;
      dwell_cnt <= dwell_nxt;
      grant     <= grant_nxt;
      m         <= m_nxt;
      m_valid   <= m_valid_nxt;
    end
  end

  assign bus.grant   = grant;
  assign bus.sel     = sel;
  assign bus.m       = m;
  assign bus.m_valid = m_valid;

endmodule
